uart_tx_arbiter: RTL

- Round-robin arbiter that shares one uart_tx serializer between NREQ byte-stream requesters.
- Each requester offers a packet as a sequence of bytes over a valid/ready handshake, with a last flag on the final byte.
- Once granted, a requester owns the transmitter until its last byte completes, so packets are never interleaved.
- The block drives tx_start/din into uart_tx and paces itself on tx_done_tick.

---
 rtl/uart_tx_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that shares one uart_tx serializer between NREQ
//   byte-stream requesters. A requester that wins arbitration keeps the
//   transmitter until the byte flagged with req_last has been sent, so packets
//   from different requesters never interleave. The round-robin pointer only
//   moves on packet completion or on a stall timeout.
//
// Ports
//   clk           system clock
//   reset         asynchronous active-high reset
//   req_valid     [NREQ]    per-requester byte valid
//   req_data      [8*NREQ]  per-requester byte, requester i on [8i+7:8i]
//   req_last      [NREQ]    final byte of a packet
//   req_ready     [NREQ]    one-cycle byte-accept strobe (combinational)
//   grant         [NREQ]    one-hot owner of the transmitter
//   tx_start      one-cycle start pulse to uart_tx
//   tx_din        [8]       byte to uart_tx, stable from tx_start to done
//   tx_done_tick  completion pulse from uart_tx
//   busy          high whenever the arbiter is not idle
//   timeout_tick  one-cycle pulse when a stalled grant is revoked
module uart_tx_arbiter #(
   parameter int unsigned NREQ        = 4,
   parameter int unsigned TIMEOUT_CYC = 1048576,
   parameter int unsigned TW          = 21
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_last,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   grant,
   output logic              tx_start,
   output logic [7:0]        tx_din,
   input  logic              tx_done_tick,
   output logic              busy,
   output logic              timeout_tick
);

   localparam int unsigned PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned TLIM_I = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
   localparam logic [TW-1:0] TLIM    = TW'(TLIM_I);
   localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      START,
      WAIT
   } state_t;

   state_t        state;
   logic [PW-1:0] g;
   logic [PW-1:0] ptr;
   logic [TW-1:0] tcnt;
   logic          last_reg;

   logic [PW-1:0] pick;
   logic [PW-1:0] pick_hi;
   logic [PW-1:0] pick_lo;
   logic          hi_ok;
   logic          lo_ok;
   logic          pick_ok;

   // Round-robin search split into two priority scans: the lowest valid index
   // above ptr wins; failing that, the lowest valid index at or below ptr
   // (the wrap-around part of the search).
   always_comb begin
      pick_hi = '0;
      pick_lo = '0;
      hi_ok   = 1'b0;
      lo_ok   = 1'b0;
      for (int unsigned j = 0; j < NREQ; j++) begin
         if (req_valid[j] && (PW'(j) > ptr) && !hi_ok) begin
            pick_hi = PW'(j);
            hi_ok   = 1'b1;
         end
         if (req_valid[j] && (PW'(j) <= ptr) && !lo_ok) begin
            pick_lo = PW'(j);
            lo_ok   = 1'b1;
         end
      end
      pick    = hi_ok ? pick_hi : pick_lo;
      pick_ok = hi_ok | lo_ok;
   end

   // Ready is only offered to the owner while waiting for its next byte.
   always_comb begin
      req_ready = '0;
      if (state == SEND && req_valid[g]) begin
         req_ready[g] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         g            <= '0;
         ptr          <= PTR_RST;
         grant        <= '0;
         tx_start     <= 1'b0;
         tx_din       <= '0;
         last_reg     <= 1'b0;
         tcnt         <= '0;
         busy         <= 1'b0;
         timeout_tick <= 1'b0;
      end else begin
         tx_start     <= 1'b0;
         timeout_tick <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_ok) begin
                  g           <= pick;
                  grant       <= '0;
                  grant[pick] <= 1'b1;
                  tcnt        <= '0;
                  busy        <= 1'b1;
                  state       <= SEND;
               end
            end
            SEND: begin
               if (req_valid[g]) begin
                  tx_din   <= req_data[{g, 3'b000} +: 8];
                  last_reg <= req_last[g];
                  tcnt     <= '0;
                  tx_start <= 1'b1;
                  state    <= START;
               end else if ((TIMEOUT_CYC != 0) && (tcnt == TLIM)) begin
                  timeout_tick <= 1'b1;
                  grant        <= '0;
                  ptr          <= g;
                  tcnt         <= '0;
                  busy         <= 1'b0;
                  state        <= IDLE;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            START: begin
               state <= WAIT;
            end
            WAIT: begin
               if (tx_done_tick) begin
                  if (last_reg) begin
                     grant <= '0;
                     ptr   <= g;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     state <= SEND;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
